glb_bank_arbiter: RTL and testbench

- Shares one bank's packet port among NUM_REQ requesters (0=proc, 1=strm, 2=pcfg) with round-robin arbitration.
- Drives the packet write and read interface of glb_bank_ctrl.
- Tags every granted read and routes the returning read data, which arrives RD_LATENCY cycles later, back to the requester that issued it.
- Defers all grants while the SRAM config path owns the bank, so no packet is silently dropped by the controller's cfg priority.

---
 rtl/glb_bank_arbiter.sv | 161 ++++++++++++++++
 tb/tb_glb_bank_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_bank_arbiter.sv
// glb_bank_arbiter
//   Round-robin arbiter that shares one GLB bank packet port among NUM_REQ
//   requesters (0=proc, 1=strm, 2=pcfg). The granted request is forwarded to
//   the bank controller's packet write/read interface. Each granted read is
//   tagged so its data, returning RD_LATENCY cycles later, goes back to the
//   requester that issued it. No grant is made while the SRAM cfg path owns
//   the bank.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   req_valid/req_wr            per-requester valid and write(1)/read(0)
//   req_addr/req_wr_data/
//   req_wr_bit_sel              packed per-requester request fields
//   req_ready                   one-hot grant (combinational)
//   rsp_rd_data/rsp_rd_valid    broadcast read data, one-hot response valid
//   cfg_busy                    cfg path active, suppresses all grants
//   packet_*                    bank controller packet interface
//   err_orphan_rsp/err_clr      sticky tag/response mismatch flag and clear
module glb_bank_arbiter #(
  parameter int unsigned NUM_REQ         = 3,
  parameter int unsigned BANK_ADDR_WIDTH = 17,
  parameter int unsigned BANK_DATA_WIDTH = 64,
  parameter int unsigned RD_LATENCY      = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0]                 req_wr,
  input  logic [NUM_REQ*BANK_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BANK_DATA_WIDTH-1:0] req_wr_data,
  input  logic [NUM_REQ*BANK_DATA_WIDTH-1:0] req_wr_bit_sel,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [BANK_DATA_WIDTH-1:0]         rsp_rd_data,
  output logic [NUM_REQ-1:0]                 rsp_rd_valid,
  input  logic                               cfg_busy,
  output logic                               packet_wr_en,
  output logic [BANK_ADDR_WIDTH-1:0]         packet_wr_addr,
  output logic [BANK_DATA_WIDTH-1:0]         packet_wr_data,
  output logic [BANK_DATA_WIDTH-1:0]         packet_wr_data_bit_sel,
  output logic                               packet_rd_en,
  output logic [BANK_ADDR_WIDTH-1:0]         packet_rd_addr,
  input  logic [BANK_DATA_WIDTH-1:0]         packet_rd_data,
  input  logic                               packet_rd_data_valid,
  output logic                               err_orphan_rsp,
  input  logic                               err_clr
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                  gnt_vld;
  logic [IDW-1:0]        gnt_id;
  int unsigned           sel;
  logic                  gnt_wr;

  logic [RD_LATENCY-1:0] tag_v_q;
  logic [IDW-1:0]        tag_id_q [RD_LATENCY];
  logic                  last_v;
  logic [IDW-1:0]        last_id;
  logic                  rsp_hit;
  logic                  err_set;
  logic                  err_q, err_d;

  // Rotating priority search starting at rr_ptr. Grants are also held off
  // while reset is asserted so the outputs reflect the cleared state.
  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    if (reset && !cfg_busy) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = (32'(rr_ptr_q) + k) % NUM_REQ;
        if (!gnt_vld && req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_id  = IDW'(idx);
        end
      end
    end
  end

  assign sel    = 32'(gnt_id);
  assign gnt_wr = gnt_vld & req_wr[sel];

  always_comb begin
    req_ready = '0;
    if (gnt_vld) req_ready[sel] = 1'b1;
  end

  always_comb begin
    packet_wr_en           = gnt_wr;
    packet_wr_addr         = '0;
    packet_wr_data         = '0;
    packet_wr_data_bit_sel = '0;
    packet_rd_en           = gnt_vld & ~req_wr[sel];
    packet_rd_addr         = '0;
    if (packet_wr_en) begin
      packet_wr_addr         = req_addr[sel*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
      packet_wr_data         = req_wr_data[sel*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
      packet_wr_data_bit_sel = req_wr_bit_sel[sel*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
    end
    if (packet_rd_en) begin
      packet_rd_addr = req_addr[sel*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
    end
  end

  assign rr_ptr_d = gnt_vld ? IDW'((32'(gnt_id) + 1) % NUM_REQ) : rr_ptr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Read tag shift pipeline: the last stage lines up with the bank's
  // packet_rd_data_valid for the read issued RD_LATENCY cycles earlier.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) tag_id_q[i] <= '0;
    end else begin
      tag_v_q[0]  <= packet_rd_en;
      tag_id_q[0] <= gnt_id;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  assign last_v  = tag_v_q[RD_LATENCY-1];
  assign last_id = tag_id_q[RD_LATENCY-1];
  assign rsp_hit = last_v & packet_rd_data_valid;

  always_comb begin
    rsp_rd_valid = '0;
    rsp_rd_data  = '0;
    if (rsp_hit) begin
      rsp_rd_valid[32'(last_id)] = 1'b1;
      rsp_rd_data                = packet_rd_data;
    end
  end

  // Any disagreement between expected tag and returned valid is an error;
  // a set in the same cycle takes priority over err_clr.
  assign err_set = last_v ^ packet_rd_data_valid;
  assign err_d   = err_set | (err_q & ~err_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_orphan_rsp = err_q;

endmodule

// File: tb/tb_glb_bank_arbiter.sv
module tb_glb_bank_arbiter;
  localparam int N  = 3;
  localparam int AW = 17;
  localparam int DW = 64;
  localparam int L  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [N-1:0]    req_valid, req_wr;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wr_data, req_wr_bit_sel;
  logic [N-1:0]    req_ready, rsp_rd_valid;
  logic [DW-1:0]   rsp_rd_data;
  logic            cfg_busy, err_clr;
  logic            packet_wr_en, packet_rd_en;
  logic [AW-1:0]   packet_wr_addr, packet_rd_addr;
  logic [DW-1:0]   packet_wr_data, packet_wr_data_bit_sel;
  logic [DW-1:0]   packet_rd_data = '0;
  logic            packet_rd_data_valid = 1'b0;
  logic            err_orphan_rsp;

  int checks = 0;
  int errors = 0;
  logic inj_orphan = 1'b0;
  logic inj_drop   = 1'b0;

  glb_bank_arbiter #(
    .NUM_REQ(N), .BANK_ADDR_WIDTH(AW), .BANK_DATA_WIDTH(DW), .RD_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_wr_bit_sel(req_wr_bit_sel),
    .req_ready(req_ready), .rsp_rd_data(rsp_rd_data), .rsp_rd_valid(rsp_rd_valid),
    .cfg_busy(cfg_busy),
    .packet_wr_en(packet_wr_en), .packet_wr_addr(packet_wr_addr),
    .packet_wr_data(packet_wr_data), .packet_wr_data_bit_sel(packet_wr_data_bit_sel),
    .packet_rd_en(packet_rd_en), .packet_rd_addr(packet_rd_addr),
    .packet_rd_data(packet_rd_data), .packet_rd_data_valid(packet_rd_data_valid),
    .err_orphan_rsp(err_orphan_rsp), .err_clr(err_clr)
  );

  function automatic logic [DW-1:0] bank_data(input logic [AW-1:0] a);
    return DW'(a) ^ 64'h1334;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Bank controller model: returns data for each read L cycles later.
  logic          bv [L] = '{default: 1'b0};
  logic [AW-1:0] ba [L] = '{default: '0};

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < L; i++) begin bv[i] = 1'b0; ba[i] = '0; end
    end else begin
      for (int i = L-1; i > 0; i--) begin bv[i] = bv[i-1]; ba[i] = ba[i-1]; end
      bv[0] = packet_rd_en;
      ba[0] = packet_rd_addr;
    end
  end

  always @(posedge clk) begin
    #2;
    packet_rd_data_valid = (bv[L-1] & ~inj_drop) | inj_orphan;
    packet_rd_data       = bv[L-1] ? bank_data(ba[L-1]) : {$urandom, $urandom};
  end

  // Reference model: pending reads are kept as a queue of {requester, addr,
  // due cycle}; grants come from a rotating search over the pointer value.
  typedef struct {int id; logic [AW-1:0] addr; int due;} rd_t;
  rd_t  pend[$];
  int   m_ptr = 0;
  logic m_err = 1'b0;
  int   m_gid = -1;
  int   cyc_n = 0;

  always @(negedge clk) begin : mdl
    int g, gg, idx;
    logic [N-1:0] e_rdy, e_rv;
    logic e_wen, e_ren, due, set;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [DW-1:0] e_wd, e_bs, e_rd;
    rd_t r;
    cyc_n++;
    if (!reset) begin
      pend.delete();
      m_ptr = 0;
      m_err = 1'b0;
    end
    g = -1;
    if (reset && !cfg_busy)
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    gg = (g < 0) ? 0 : g;
    e_rdy   = (g >= 0) ? N'(1 << g) : '0;
    e_wen   = (g >= 0) && req_wr[gg];
    e_ren   = (g >= 0) && !req_wr[gg];
    e_waddr = e_wen ? req_addr[gg*AW +: AW] : '0;
    e_wd    = e_wen ? req_wr_data[gg*DW +: DW] : '0;
    e_bs    = e_wen ? req_wr_bit_sel[gg*DW +: DW] : '0;
    e_raddr = e_ren ? req_addr[gg*AW +: AW] : '0;
    due  = (pend.size() > 0) && (pend[0].due == cyc_n);
    e_rv = '0;
    e_rd = '0;
    if (due && packet_rd_data_valid) begin
      e_rv = N'(1 << pend[0].id);
      e_rd = bank_data(pend[0].addr);
    end
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("wr_en", 64'(packet_wr_en), 64'(e_wen));
    chk("wr_addr", 64'(packet_wr_addr), 64'(e_waddr));
    chk("wr_data", packet_wr_data, e_wd);
    chk("wr_bit_sel", packet_wr_data_bit_sel, e_bs);
    chk("rd_en", 64'(packet_rd_en), 64'(e_ren));
    chk("rd_addr", 64'(packet_rd_addr), 64'(e_raddr));
    chk("rsp_valid", 64'(rsp_rd_valid), 64'(e_rv));
    chk("rsp_data", rsp_rd_data, e_rd);
    chk("err_flag", 64'(err_orphan_rsp), 64'(m_err));
    if (reset) begin
      set   = due != packet_rd_data_valid;
      m_err = set ? 1'b1 : (err_clr ? 1'b0 : m_err);
      if (due) void'(pend.pop_front());
      if (e_ren) begin
        r.id = g; r.addr = e_raddr; r.due = cyc_n + L;
        pend.push_back(r);
      end
      if (g >= 0) m_ptr = (g + 1) % N;
    end
    m_gid = g;
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] bs);
    req_valid[i] = 1'b1;
    req_wr[i]    = wr;
    req_addr[i*AW +: AW]       = a;
    req_wr_data[i*DW +: DW]    = d;
    req_wr_bit_sel[i*DW +: DW] = bs;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b0; req_valid = '0;
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] t4_addr [3];
    int            t4_id   [3];
    reset = 1'b0; req_valid = '0; req_wr = '0; req_addr = '0;
    req_wr_data = '0; req_wr_bit_sel = '0; cfg_busy = 1'b0; err_clr = 1'b0;
    repeat (2) cyc();
    smp();
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_err", 64'(err_orphan_rsp), 64'h0);
    chk("rst_rd_en", 64'(packet_rd_en), 64'h0);

    // Single write from requester 1 right after reset release
    cyc();
    reset = 1'b1;
    set_req(1, 1'b1, 17'h40, 64'hDEAD_BEEF, '1);
    smp();
    chk("t1_ready", 64'(req_ready), 64'h2);
    chk("t1_wr_en", 64'(packet_wr_en), 64'h1);
    chk("t1_wr_addr", 64'(packet_wr_addr), 64'h40);
    chk("t1_wr_data", packet_wr_data, 64'hDEAD_BEEF);
    cyc();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), 64'(i), '1);
    smp();
    chk("t1_ptr2", 64'(req_ready), 64'h4);

    // All valid from rr_ptr=0: strict rotation
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(k*4+i), 64'(k), '1);
      smp();
      chk("t2_order", 64'(req_ready), 64'(1 << (k % 3)));
      cyc();
    end
    req_valid = '0;

    // Single read from requester 2, response L cycles later
    set_req(2, 1'b0, 17'h100, '0, '0);
    smp();
    chk("t3_grant", 64'(req_ready), 64'h4);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      req_valid = '0;
      smp();
      chk("t3_rsp_valid", 64'(rsp_rd_valid), (k == 3) ? 64'h4 : 64'h0);
      if (k == 3) chk("t3_rsp_data", rsp_rd_data, 64'h1234);
    end

    // Back-to-back reads 0,1,0
    t4_id   = '{0, 1, 0};
    t4_addr = '{17'h010, 17'h020, 17'h030};
    for (int k = 0; k < 6; k++) begin
      cyc();
      req_valid = '0;
      if (k < 3) set_req(t4_id[k], 1'b0, t4_addr[k], '0, '0);
      smp();
      if (k >= 3) begin
        chk("t4_rsp_valid", 64'(rsp_rd_valid), 64'(1 << t4_id[k-3]));
        chk("t4_rsp_data", rsp_rd_data, bank_data(t4_addr[k-3]));
      end
    end

    // cfg_busy blocks grants
    cyc();
    req_valid = '0;
    cfg_busy  = 1'b1;
    set_req(0, 1'b1, 17'h77, 64'h5, '1);
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("t5_busy_ready", 64'(req_ready), 64'h0);
      chk("t5_busy_en", 64'({packet_wr_en, packet_rd_en}), 64'h0);
      cyc();
    end
    cfg_busy = 1'b0;
    smp();
    chk("t5_resume", 64'(req_ready), 64'h1);

    // Orphan response and clear
    cyc();
    req_valid  = '0;
    inj_orphan = 1'b1;
    smp();
    chk("t6_no_rsp", 64'(rsp_rd_valid), 64'h0);
    cyc();
    inj_orphan = 1'b0;
    err_clr    = 1'b1;
    smp();
    chk("t6_err_set", 64'(err_orphan_rsp), 64'h1);
    cyc();
    err_clr = 1'b0;
    smp();
    chk("t6_err_clr", 64'(err_orphan_rsp), 64'h0);

    // Reset while a read is in flight
    cyc();
    set_req(1, 1'b0, 17'h55, '0, '0);
    cyc();
    req_valid = '0;
    reset     = 1'b0;
    cyc();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("t6_rst_no_rsp", 64'(rsp_rd_valid), 64'h0);
      cyc();
    end
    chk("t6_rst_err", 64'(err_orphan_rsp), 64'h0);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || m_gid == i) begin
          if ($urandom_range(2) != 0)
            set_req(i, 1'($urandom), AW'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
          else
            req_valid[i] = 1'b0;
        end
      end
      cfg_busy   = ($urandom_range(7) == 0);
      err_clr    = ($urandom_range(15) == 0);
      inj_orphan = ($urandom_range(63) == 0);
      inj_drop   = ($urandom_range(63) == 0);
      reset      = ($urandom_range(399) != 0);
      cyc();
    end
    reset = 1'b1;
    req_valid = '0;
    inj_orphan = 1'b0;
    inj_drop = 1'b0;
    repeat (5) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
